// File: rtl/load_store_unit.sv
// Memory-access stage: executes one RISC-V load/store against a word-wide
// data memory over a req/ack handshake. It stalls the pipeline while the
// access is outstanding and returns extended load data or a fault.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | no access outstanding; waiting for start_i
//   WAIT  | mem_req_o held high until mem_ack_i or the timeout expires
//   RESP  | one-cycle done_o pulse carrying fault_o / rdata_o
module load_store_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic                  mem_read_i,
  input  logic                  mem_write_i,
  input  logic [2:0]            funct3_i,
  input  logic [DATA_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  fault_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [3:0]            mem_be_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_ack_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  // Wide enough to hold TIMEOUT_CYCLES-1, the value loaded at accept.
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   tmo_cnt;
  logic [1:0]      lane_q;
  logic [2:0]      f3_q;

  logic                  op_one;
  logic                  op_both;
  logic                  f3_ok;
  logic                  misalign;
  logic                  acc_fault;
  logic [3:0]            be_nxt;
  logic [DATA_WIDTH-1:0] wdata_nxt;
  logic [7:0]            rd_byte;
  logic [15:0]           rd_half;
  logic [DATA_WIDTH-1:0] load_ext;

  // Decode the presented instruction: legality, alignment, lanes, store data.
  always_comb begin
    op_one   = mem_read_i ^ mem_write_i;
    op_both  = mem_read_i & mem_write_i;
    f3_ok    = 1'b0;
    misalign = 1'b0;
    if (mem_read_i) begin
      case (funct3_i)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_ok = 1'b1;
        default:                                f3_ok = 1'b0;
      endcase
    end else begin
      case (funct3_i)
        3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
        default:                f3_ok = 1'b0;
      endcase
    end
    case (funct3_i[1:0])
      2'b01:   misalign = addr_i[0];
      2'b10:   misalign = |addr_i[1:0];
      default: misalign = 1'b0;
    endcase
    acc_fault = op_both | (op_one & (~f3_ok | misalign));

    case (funct3_i[1:0])
      2'b00:   be_nxt = 4'b0001 << addr_i[1:0];
      2'b01:   be_nxt = 4'b0011 << {addr_i[1], 1'b0};
      default: be_nxt = 4'b1111;
    endcase

    wdata_nxt = '0;
    if (mem_write_i) begin
      case (funct3_i[1:0])
        2'b00:   wdata_nxt = {4{wdata_i[7:0]}};
        2'b01:   wdata_nxt = {2{wdata_i[15:0]}};
        default: wdata_nxt = wdata_i;
      endcase
    end
  end

  // Pick the addressed lane out of the returned word and extend it.
  always_comb begin
    case (lane_q)
      2'd0:    rd_byte = mem_rdata_i[7:0];
      2'd1:    rd_byte = mem_rdata_i[15:8];
      2'd2:    rd_byte = mem_rdata_i[23:16];
      default: rd_byte = mem_rdata_i[31:24];
    endcase
    rd_half = lane_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (f3_q)
      3'b000:  load_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_ext = {{16{rd_half[15]}}, rd_half};
      3'b100:  load_ext = {24'd0, rd_byte};
      3'b101:  load_ext = {16'd0, rd_half};
      default: load_ext = mem_rdata_i;
    endcase
  end

  // Stall while an access is being accepted or is outstanding; low in RESP
  // so the pipeline advances in the done cycle.
  assign busy_o = (state == WAIT) | ((state == IDLE) & start_i & op_one);

  // Access sequencer with registered handshake and response outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      tmo_cnt     <= '0;
      lane_q      <= 2'd0;
      f3_q        <= 3'd0;
      done_o      <= 1'b0;
      fault_o     <= 1'b0;
      rdata_o     <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_be_o    <= 4'd0;
      mem_wdata_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_o  <= 1'b0;
          fault_o <= 1'b0;
          if (start_i && (mem_read_i || mem_write_i)) begin
            if (acc_fault) begin
              state   <= RESP;
              done_o  <= 1'b1;
              fault_o <= 1'b1;
              rdata_o <= '0;
            end else begin
              state       <= WAIT;
              tmo_cnt     <= CW'(TIMEOUT_CYCLES - 1);
              lane_q      <= addr_i[1:0];
              f3_q        <= funct3_i;
              mem_req_o   <= 1'b1;
              mem_we_o    <= mem_write_i;
              mem_addr_o  <= {addr_i[DATA_WIDTH-1:2], 2'b00};
              mem_be_o    <= be_nxt;
              mem_wdata_o <= wdata_nxt;
            end
          end
        end
        WAIT: begin
          // An ack in the final counted cycle still wins over the timeout.
          if (mem_ack_i) begin
            state     <= RESP;
            mem_req_o <= 1'b0;
            done_o    <= 1'b1;
            fault_o   <= 1'b0;
            rdata_o   <= mem_we_o ? '0 : load_ext;
          end else if (tmo_cnt == '0) begin
            state     <= RESP;
            mem_req_o <= 1'b0;
            done_o    <= 1'b1;
            fault_o   <= 1'b1;
            rdata_o   <= '0;
          end else begin
            tmo_cnt <= tmo_cnt - CW'(1);
          end
        end
        RESP: begin
          state   <= IDLE;
          done_o  <= 1'b0;
          fault_o <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          done_o    <= 1'b0;
          fault_o   <= 1'b0;
          mem_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed + randomized bench for load_store_unit with a byte-arithmetic
// reference model of RISC-V load/store semantics.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i, mem_read_i, mem_write_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, wdata_i;
  logic        busy_o, done_o, fault_o;
  logic [31:0] rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  int n_chk  = 0;
  int n_fail = 0;

  load_store_unit #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .mem_read_i(mem_read_i),
    .mem_write_i(mem_write_i), .funct3_i(funct3_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .busy_o(busy_o), .done_o(done_o), .fault_o(fault_o),
    .rdata_o(rdata_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---- reference model ----
  function automatic bit m_fault(input bit rd, input bit wr, input logic [2:0] f3,
                                 input logic [31:0] a);
    int nb;
    if (rd && wr) return 1'b1;
    if (rd && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
    if (wr && !(f3 inside {3'd0, 3'd1, 3'd2})) return 1'b1;
    nb = 1 << f3[1:0];
    return (int'(a % 4) % nb) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int nb  = 1 << f3[1:0];
    int off = int'(a % 4);
    return 4'(((1 << nb) - 1) << off);
  endfunction

  function automatic logic [31:0] m_wdata(input bit wr, input logic [2:0] f3,
                                          input logic [31:0] wd);
    logic [31:0] r = '0;
    int nb = 1 << f3[1:0];
    if (!wr) return '0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nb) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_rdata(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] mr);
    int nb = 1 << f3[1:0];
    logic [31:0] mask = 32'((64'd1 << (8*nb)) - 64'd1);
    logic [31:0] v = (mr >> (8 * int'(a % 4))) & mask;
    if (!f3[2] && nb < 4 && v[8*nb-1]) v = v | ~mask;
    return v;
  endfunction

  // One complete instruction; d = ack after d silent WAIT cycles (>=16: none).
  task automatic access(input bit rd, input bit wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rdv, input int d);
    bit flt;
    logic [31:0] erd;
    @(negedge clk);
    start_i = 1'b1; mem_read_i = rd; mem_write_i = wr; funct3_i = f3;
    addr_i = a; wdata_i = wd;
    mem_ack_i = 1'($urandom_range(0, 1));   // ignored outside WAIT
    mem_rdata_i = $urandom;
    #1;
    if (!rd && !wr) begin
      chk("noop_busy", busy_o, 0);
      @(negedge clk);
      start_i = 1'b0; mem_ack_i = 1'b0;
      #1;
      chk("noop_done", done_o, 0);
      chk("noop_req", mem_req_o, 0);
      return;
    end
    flt = m_fault(rd, wr, f3, a);
    if (!flt) chk("accept_busy", busy_o, 1);
    @(negedge clk);
    // start_i stays high with scrambled fields: it must be ignored now
    addr_i = $urandom; wdata_i = $urandom; funct3_i = 3'($urandom);
    mem_ack_i = 1'b0;
    if (flt) begin
      #1;
      chk("flt_done", done_o, 1);
      chk("flt_fault", fault_o, 1);
      chk("flt_req", mem_req_o, 0);
      chk("flt_rdata", rdata_o, 0);
      chk("flt_busy", busy_o, 0);
      @(negedge clk);
      start_i = 1'b0;
      #1;
      chk("flt_done_clr", done_o, 0);
      chk("flt_fault_clr", fault_o, 0);
      return;
    end
    for (int k = 0; k < 16; k++) begin
      #1;
      chk("wait_req", mem_req_o, 1);
      chk("wait_busy", busy_o, 1);
      chk("wait_addr", mem_addr_o, {a[31:2], 2'b00});
      chk("wait_we", mem_we_o, 32'(wr));
      chk("wait_be", mem_be_o, m_be(f3, a));
      chk("wait_wdata", mem_wdata_o, m_wdata(wr, f3, wd));
      if (k == d) begin
        mem_ack_i = 1'b1; mem_rdata_i = rdv;
      end
      @(negedge clk);
      mem_ack_i = 1'b0; mem_rdata_i = $urandom;
      if (k == d) break;
    end
    start_i = 1'b0;
    erd = (d > 15 || wr) ? 32'd0 : m_rdata(f3, a, rdv);
    #1;
    chk("resp_done", done_o, 1);
    chk("resp_fault", fault_o, 32'(d > 15));
    chk("resp_rdata", rdata_o, erd);
    chk("resp_req", mem_req_o, 0);
    chk("resp_busy", busy_o, 0);
    @(negedge clk);
    #1;
    chk("post_done", done_o, 0);
    chk("post_rdata_hold", rdata_o, erd);
  endtask

  initial begin
    reset = 1'b0; start_i = 0; mem_read_i = 0; mem_write_i = 0; funct3_i = 0;
    addr_i = 0; wdata_i = 0; mem_ack_i = 0; mem_rdata_i = 0;
    #2;
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_fault", fault_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_req", mem_req_o, 0);
    chk("rst_be", mem_be_o, 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;

    // directed cases from the plan
    access(1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0);
    chk("lw_value", rdata_o, 32'hDEADBEEF);
    access(1, 0, 3'b000, 32'h103, 0, 32'h80AA55CC, 0);
    chk("lb_value", rdata_o, 32'hFFFFFF80);
    access(1, 0, 3'b100, 32'h103, 0, 32'h80AA55CC, 0);
    chk("lbu_value", rdata_o, 32'h00000080);
    access(1, 0, 3'b101, 32'h102, 0, 32'h80AA55CC, 1);
    chk("lhu_value", rdata_o, 32'h000080AA);
    access(0, 1, 3'b000, 32'h201, 32'h123456AB, 0, 3);
    access(0, 1, 3'b001, 32'h202, 32'h123456AB, 0, 3);
    access(1, 0, 3'b010, 32'h102, 0, 0, 0);           // misaligned LW
    access(1, 1, 3'b010, 32'h100, 0, 0, 0);           // both flags
    access(1, 0, 3'b011, 32'h100, 0, 0, 0);           // illegal load funct3
    access(0, 1, 3'b100, 32'h100, 0, 0, 0);           // illegal store funct3
    access(0, 0, 3'b010, 32'h100, 0, 0, 0);           // no-op
    access(1, 0, 3'b010, 32'h300, 0, 32'h11223344, 16); // timeout
    access(1, 0, 3'b010, 32'h304, 0, 32'h55667788, 15); // ack in last cycle
    chk("late_ack_value", rdata_o, 32'h55667788);

    // asynchronous reset while in WAIT
    @(negedge clk);
    start_i = 1; mem_read_i = 1; mem_write_i = 0; funct3_i = 3'b010; addr_i = 32'h400;
    @(negedge clk);
    start_i = 0;
    #1;
    chk("pre_rst_req", mem_req_o, 1);
    #2 reset = 1'b0;
    #1;
    chk("arst_req", mem_req_o, 0);
    chk("arst_busy", busy_o, 0);
    chk("arst_rdata", rdata_o, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      chk("arst_no_done", done_o, 0);
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("after_rst_no_done", done_o, 0);
    end
    access(1, 0, 3'b010, 32'h400, 0, 32'hCAFEF00D, 1);
    chk("after_rst_lw", rdata_o, 32'hCAFEF00D);

    // randomized accesses
    for (int i = 0; i < 80; i++) begin
      int op = $urandom_range(0, 9);
      bit rd = (op >= 2 && op <= 5) || op == 1;
      bit wr = op >= 6 || op == 1;
      logic [2:0] f3;
      logic [31:0] a = $urandom;
      int d;
      if ($urandom_range(0, 3) != 0) begin
        if (wr && !rd) f3 = 3'($urandom_range(0, 2));
        else begin
          int p = $urandom_range(0, 4);
          f3 = (p < 3) ? 3'(p) : 3'(p + 1);
        end
      end else f3 = 3'($urandom);
      if ($urandom_range(0, 1) != 0) a[1:0] = 2'b00;
      d = $urandom_range(0, 3);
      if ($urandom_range(0, 15) == 0) d = $urandom_range(15, 16);
      access(rd, wr, f3, a, $urandom, $urandom, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
